// File: rtl/mem_arbiter_if.sv
// Requester and physical-memory signal bundle shared by the instruction side,
// the data side and the single pmem port of mem_arbiter.
interface mem_arbiter_if #(
    parameter int LINE_WIDTH = 256
) ();
    logic                  i_read;
    logic [31:0]           i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [31:0]           d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [31:0]           pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    // Arbiter view
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    // Caches plus memory view
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between the I-cache and D-cache. The data side has
// priority; an aging counter forces an instruction grant after STARVE_LIMIT data wins.
//
// state   | meaning
// IDLE    | no transaction, arbitrate pending requests
// SERVE_I | instruction-side read in flight on pmem
// SERVE_D | data-side read or writeback in flight on pmem
module mem_arbiter #(
    parameter int LINE_WIDTH   = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;

    logic                  i_pend, d_pend, i_forced;
    logic                  i_resp, d_resp, pmem_read, pmem_write;
    logic [LINE_WIDTH-1:0] i_rdata, d_rdata;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;

        i_pend   = bus.i_read;
        d_pend   = bus.d_read | bus.d_write;
        i_forced = i_pend && (starve_cnt_q == LIMIT);

        case (state_q)
            IDLE: begin
                if (d_pend && !i_forced) begin
                    state_d = SERVE_D;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    // read+write together is resolved as a writeback
                    wr_d    = bus.d_write;
                    if (i_pend) begin
                        starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT
                                                               : starve_cnt_q + CNT_W'(1);
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (i_pend) begin
                    state_d      = SERVE_I;
                    addr_d       = bus.i_addr;
                    wr_d         = 1'b0;
                    starve_cnt_d = '0;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = bus.pmem_rdata;
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                pmem_read  = !wr_q;
                pmem_write = wr_q;
                if (bus.pmem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = bus.pmem_rdata;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
        end
    end

    assign bus.i_resp       = i_resp;
    assign bus.i_rdata      = i_rdata;
    assign bus.d_resp       = d_resp;
    assign bus.d_rdata      = d_rdata;
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_write   = pmem_write;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected pmem commands and responses,
// independent monitors pop and compare them; a small memory model answers pmem.
module tb_mem_arbiter;
    localparam int LW = 256;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.LINE_WIDTH(LW)) bus ();

    mem_arbiter #(.LINE_WIDTH(LW), .STARVE_LIMIT(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        int            starve;
    } cmd_t;

    typedef struct {
        logic          is_d;
        logic          chk_data;
        logic [LW-1:0] rdata;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];

    int n_cmp = 0;
    int n_bad = 0;

    int mem_lat    = 3;
    bit mem_en     = 1'b1;
    int stray_req  = 0;
    int stray_done = 0;
    logic [LW-1:0] mem_img [logic [31:0]];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_at(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    function automatic void push_cmd(input logic wr, input logic [31:0] a,
                                     input logic [LW-1:0] wd, input int st);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = wd; c.starve = st;
        exp_cmd.push_back(c);
    endfunction

    function automatic void push_rsp(input logic is_d, input logic chk, input logic [LW-1:0] rd);
        rsp_t r;
        r.is_d = is_d; r.chk_data = chk; r.rdata = rd;
        exp_rsp.push_back(r);
    endfunction

    // Memory model: answers a held command after mem_lat cycles, or emits stray pulses on demand
    initial begin
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = {LW{1'b1}};
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                cnt = 0;
            end else if (stray_req != stray_done) begin
                stray_done++;
                bus.pmem_resp = 1'b1;
            end else if (mem_en && (bus.pmem_read || bus.pmem_write)) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) mem_img[bus.pmem_address] = bus.pmem_wdata;
                    else bus.pmem_rdata = line_at(bus.pmem_address);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Command monitor: first cycle of each pmem command is scored, then held stable
    initial begin
        bit   active;
        cmd_t c;
        logic [31:0]   s_addr;
        logic [LW-1:0] s_wdata;
        logic [1:0]    s_rw;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (!active) begin
                    active  = 1'b1;
                    s_addr  = bus.pmem_address;
                    s_wdata = bus.pmem_wdata;
                    s_rw    = {bus.pmem_read, bus.pmem_write};
                    if (exp_cmd.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL cmd_unexpected: got rw=%b addr=%h required no command",
                                 s_rw, s_addr);
                    end else begin
                        c = exp_cmd.pop_front();
                        check("cmd_rw", LW'(s_rw), LW'({!c.wr, c.wr}));
                        check("cmd_addr", LW'(s_addr), LW'(c.addr));
                        if (c.wr) check("cmd_wdata", s_wdata, c.wdata);
                        check("starve_cnt", LW'(dut.starve_cnt_q), LW'(c.starve));
                    end
                end else begin
                    check("hold_addr", LW'(bus.pmem_address), LW'(s_addr));
                    check("hold_rw", LW'({bus.pmem_read, bus.pmem_write}), LW'(s_rw));
                    check("hold_wdata", bus.pmem_wdata, s_wdata);
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.i_resp || bus.d_resp) begin
                    if (bus.i_resp && bus.d_resp) begin
                        n_cmp++; n_bad++;
                        $display("FAIL resp_both: got i_resp=1 d_resp=1 required one");
                    end else if (exp_rsp.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL resp_unexpected: got i_resp=%b d_resp=%b required none",
                                 bus.i_resp, bus.d_resp);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("resp_side", LW'(bus.d_resp), LW'(r.is_d));
                        if (r.chk_data) begin
                            if (r.is_d) check("d_rdata", bus.d_rdata, r.rdata);
                            else        check("i_rdata", bus.i_rdata, r.rdata);
                        end
                    end
                end else begin
                    check("rdata_idle", bus.i_rdata | bus.d_rdata, '0);
                end
            end
        end
    end

    task automatic req_i(input logic [31:0] a);
        int n;
        bus.i_read = 1'b1;
        bus.i_addr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.i_resp && n < 200);
        if (!bus.i_resp) begin
            n_cmp++; n_bad++;
            $display("FAIL i_timeout: got no i_resp in %0d cycles required i_resp", n);
        end
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;
    endtask

    task automatic req_d(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [LW-1:0] wd, input int nresp, input bit move);
        int n;
        bus.d_read  = rd;
        bus.d_write = wr;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        for (int k = 0; k < nresp; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (move && n == 2) begin
                    bus.d_addr  = 32'hDEAD_0000;
                    bus.d_wdata = '0;
                end
            end while (!bus.d_resp && n < 200);
            if (!bus.d_resp) begin
                n_cmp++; n_bad++;
                $display("FAIL d_timeout: got no d_resp in %0d cycles required d_resp", n);
                break;
            end
            if (k < nresp - 1) @(posedge clk);
        end
        @(posedge clk);
        #1;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [LW-1:0] wline;
        logic [LW-1:0] illegal_line;
        int n;
        wline        = {8{32'h1234_5678}};
        illegal_line = {8{32'h0BAD_F00D}};
        bus.i_read  = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        mem_img[32'h0000_0040] = {32{8'hA5}};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_pmem_rw", LW'({bus.pmem_read, bus.pmem_write}), '0);
        check("rst_pmem_addr", LW'(bus.pmem_address), '0);
        check("rst_pmem_wdata", bus.pmem_wdata, '0);
        check("rst_resp", LW'({bus.i_resp, bus.d_resp}), '0);
        check("rst_starve", LW'(dut.starve_cnt_q), '0);
        @(posedge clk);
        #1;

        // Instruction-only read with grant latency
        push_cmd(1'b0, 32'h40, '0, 0);
        push_rsp(1'b0, 1'b1, {32{8'hA5}});
        fork
            req_i(32'h40);
            begin
                @(negedge clk);
                check("lat_idle", LW'(bus.pmem_read), '0);
                @(negedge clk);
                check("lat_grant", LW'(bus.pmem_read), LW'(1));
            end
        join
        gap();

        // Writeback with requester inputs moving mid-transaction
        push_cmd(1'b1, 32'h1000, wline, 0);
        push_rsp(1'b1, 1'b0, '0);
        req_d(1'b0, 1'b1, 32'h1000, wline, 1, 1'b1);
        gap();

        // Read back the written line on the data side
        push_cmd(1'b0, 32'h1000, '0, 0);
        push_rsp(1'b1, 1'b1, wline);
        req_d(1'b1, 1'b0, 32'h1000, '0, 1, 1'b0);
        gap();

        // Simultaneous requests: D first, then I
        push_cmd(1'b0, 32'h70, '0, 1);
        push_rsp(1'b1, 1'b1, line_at(32'h70));
        push_cmd(1'b0, 32'h60, '0, 0);
        push_rsp(1'b0, 1'b1, line_at(32'h60));
        fork
            req_i(32'h60);
            req_d(1'b1, 1'b0, 32'h70, '0, 1, 1'b0);
        join
        gap();

        // Starvation: D held across 5 responses while I waits; I wins after 4 D grants
        for (int k = 1; k <= SL; k++) begin
            push_cmd(1'b0, 32'h2000, '0, k);
            push_rsp(1'b1, 1'b1, line_at(32'h2000));
        end
        push_cmd(1'b0, 32'h50, '0, 0);
        push_rsp(1'b0, 1'b1, line_at(32'h50));
        push_cmd(1'b0, 32'h2000, '0, 0);
        push_rsp(1'b1, 1'b1, line_at(32'h2000));
        fork
            req_i(32'h50);
            req_d(1'b1, 1'b0, 32'h2000, '0, SL + 1, 1'b0);
        join
        gap();

        // Reset during SERVE_D, then a late pmem_resp
        mem_en = 1'b0;
        push_cmd(1'b0, 32'h3000, '0, 0);
        bus.d_read = 1'b1;
        bus.d_addr = 32'h3000;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.d_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_pmem_rw", LW'({bus.pmem_read, bus.pmem_write}), '0);
        check("abort_resp", LW'({bus.i_resp, bus.d_resp}), '0);
        check("abort_addr", LW'(bus.pmem_address), '0);
        check("abort_wdata", bus.pmem_wdata, '0);
        @(posedge clk);
        #1;
        stray_req++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pmem_resp && n < 20);
        check("late_resp_seen", LW'(bus.pmem_resp), LW'(1));
        check("late_resp_ignored", LW'({bus.i_resp, bus.d_resp}), '0);
        mem_en = 1'b1;
        gap();

        // Illegal read+write is treated as a write
        push_cmd(1'b1, 32'h4000, illegal_line, 0);
        push_rsp(1'b1, 1'b0, '0);
        req_d(1'b1, 1'b1, 32'h4000, illegal_line, 1, 1'b0);
        gap();

        // Stray pmem_resp while IDLE
        stray_req++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.pmem_resp && n < 20);
        check("stray_resp_seen", LW'(bus.pmem_resp), LW'(1));
        check("stray_resp_ignored", LW'({bus.i_resp, bus.d_resp}), '0);
        gap();

        n = 0;
        while ((exp_cmd.size() != 0 || exp_rsp.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("cmd_queue_drained", LW'(exp_cmd.size()), '0);
        check("rsp_queue_drained", LW'(exp_rsp.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-cache side, which feeds IF, and the data-cache side, which feeds MEM.
- Latches one requester's command per transaction and drives the pmem port from the latched copy.
- Routes the response back to the requester that owns the transaction.
- Data side normally has priority. An aging counter stops the instruction side from starving, so IF_resp and MEM_resp can never both stall indefinitely.

Parameters:
- LINE_WIDTH, 256, cache line width in bits for rdata/wdata.
- STARVE_LIMIT, 4, maximum consecutive data-side grants while the instruction side is pending before the instruction side is forced to win. Must be at least 1.

Ports:
- clk  input  1  clock; every state element updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- i_read  input  1  instruction-side line read request; held until i_resp.
- i_addr  input  32  instruction-side line address.
- i_rdata  output  LINE_WIDTH  instruction-side read data; valid when i_resp=1.
- i_resp  output  1  instruction-side transaction-complete pulse.
- d_read  input  1  data-side line read request; held until d_resp.
- d_write  input  1  data-side line write request (writeback); held until d_resp.
- d_addr  input  32  data-side line address.
- d_wdata  input  LINE_WIDTH  data-side write data.
- d_rdata  output  LINE_WIDTH  data-side read data; valid when d_resp=1.
- d_resp  output  1  data-side transaction-complete pulse.
- pmem_read  output  1  memory read command.
- pmem_write  output  1  memory write command.
- pmem_address  output  32  memory address (latched).
- pmem_wdata  output  LINE_WIDTH  memory write data (latched).
- pmem_rdata  input  LINE_WIDTH  memory read data.
- pmem_resp  input  1  memory completion, one-cycle pulse.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Reset (synchronous, takes effect at the clock edge where rst=1):
  - state=IDLE and starve_cnt=0.
  - Latched address, latched wdata and the latched write flag all cleared to 0.
  - From the cycle after reset: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0.
- Reset mid-transaction abandons the transaction. No resp is issued, and a pmem_resp arriving later while IDLE is ignored.
- IDLE arbitration, evaluated each cycle; the grant takes effect at the next edge:
  - Neither side pending: stay IDLE.
  - Only i_read: go to SERVE_I; latch i_addr; write flag=0.
  - Only d_read or d_write: go to SERVE_D; latch d_addr and d_wdata; write flag=d_write.
  - Both sides pending and starve_cnt==STARVE_LIMIT: instruction side wins.
  - Both sides pending and starve_cnt<STARVE_LIMIT: data side wins.
- Aging counter:
  - Any SERVE_I grant clears starve_cnt to 0.
  - A SERVE_D grant made while i_read=1 increments starve_cnt, saturating at STARVE_LIMIT.
  - A SERVE_D grant made while i_read=0 clears starve_cnt to 0.
- d_read and d_write both asserted is illegal. The arbiter treats it as a write: latches write flag=1 and ignores the read.
- SERVE_I:
  - pmem_read=1, pmem_write=0; pmem_address and pmem_wdata come from the latches.
  - On pmem_resp=1: i_resp=1 combinationally that cycle, i_rdata=pmem_rdata, and the next state is IDLE.
- SERVE_D:
  - pmem_read=!write flag, pmem_write=write flag.
  - On pmem_resp=1: d_resp=1 combinationally that cycle, d_rdata=pmem_rdata (don't-care for writes), and the next state is IDLE.
- Outside their response cycles, i_rdata and d_rdata output 0.
- pmem_* stay stable for the whole transaction even if the requester's inputs change.
- Minimum gap: one IDLE cycle between transactions. Arbitration latency is 1 cycle after the request is seen in IDLE.
- Requesters must drop their request the cycle after they see resp. A request still asserted in IDLE is treated as a new transaction.
- pmem_resp while IDLE: ignored, no resp pulse.
- Requests arriving during a SERVE state wait for IDLE; they are never preempted.

Test Plan:
- Instruction-only read:
  - Stimulus: i_read=1, i_addr=0x0000_0040; memory returns pmem_resp after 3 cycles with rdata=0xA5..A5.
  - Required: pmem_read=1 and pmem_address=0x40 starting 1 cycle after i_read is seen in IDLE; i_resp=1 for exactly 1 cycle with i_rdata=0xA5..A5; d_resp stays 0.
- Data writeback:
  - Stimulus: d_write=1, d_addr=0x1000, d_wdata=0x1234..; d_addr is changed mid-transaction.
  - Required: pmem_write=1, pmem_read=0, pmem_address stays 0x1000 throughout; d_resp pulses on pmem_resp.
- Simultaneous requests:
  - Stimulus: i_read and d_read asserted together from IDLE with starve_cnt=0.
  - Required: SERVE_D first, then one IDLE cycle, then SERVE_I; starve_cnt reads 1 after the D grant and 0 after the I grant.
- Starvation:
  - Stimulus: i_read held continuously while d_read is re-asserted after each d_resp, STARVE_LIMIT=4.
  - Required: exactly 4 D transactions, then the instruction side is granted.
- Reset mid-transaction:
  - Stimulus: rst=1 for 1 cycle during SERVE_D, then pmem_resp arrives 2 cycles later.
  - Required: pmem_read, pmem_write, d_resp and i_resp all 0 from the cycle after reset; the late pmem_resp produces no resp pulse.
- Illegal request and stray response:
  - Stimulus: d_read=d_write=1; separately, pmem_resp pulsed while IDLE.
  - Required: pmem_write=1 and pmem_read=0 for the illegal request; the stray pmem_resp produces no i_resp or d_resp.
